coherence_bus_ctrl: RTL
=======================

# coherence_bus_ctrl

Two-CPU snooping memory/coherence controller between the per-CPU instruction and data caches and the single shared RAM port. It arbitrates instruction fetches, data-block loads, write-backs and coherence transactions onto RAM one at a time. It drives snoop/invalidate requests to the non-requesting data cache and performs cache-to-cache transfers of dirty blocks. Data blocks are two words; instruction fetches are one word.

## Interface
- CPUS, 2: number of caches served. Only 2 is supported.
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- iREN  in  [1:0]  per-CPU instruction read request.
- iaddr  in  [1:0][31:0]  instruction word address.
- dREN  in  [1:0]  data read, i.e. block fill.
- dWEN  in  [1:0]  data write, i.e. write-back or snoop supply.
- daddr  in  [1:0][31:0]  data word address.
- dstore  in  [1:0][31:0]  data write word.
- ccwrite  in  [1:0]  requester: wants M state; snooper: holds a dirty copy.
- cctrans  in  [1:0]  cache requests a coherence state transition.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- iwait, dwait  out  [1:0]  high = cache must hold; low for exactly the completing cycle.
- iload, dload  out  [1:0][31:0]  returned words.
- ccwait  out  [1:0]  snooped cache must stall its CPU.
- ccinv  out  [1:0]  snooped cache must invalidate the snooped block.
- ccsnoopaddr  out  [1:0][31:0]  snooped address.
- ramaddr, ramstore  out  32  RAM address and write data.
- ramREN, ramWEN  out  1  RAM strobes. Never both high at once.

## Operation
- States: IDLE, IFETCH, WB0, WB1, SNOOP, C2C0, C2C1, LOAD0, LOAD1, INVONLY.
- Arbitration happens in IDLE only.
  - Data requests (dREN|dWEN|cctrans) beat instruction requests.
  - Data: round-robin pointer `dptr`. The other CPU wins when both request. `dptr` flips after each completed data transaction.
  - Instruction: separate round-robin pointer `iptr`, same rule.
  - Winner index r is registered; o = ~r.
- IFETCH: ramREN=1, ramaddr=iaddr[r], iload[r]=ramload. When ramstate==ACCESS: iwait[r]=0, then IDLE.
- Write-back (dWEN[r] & ~cctrans[r]): WB0 then WB1.
  - ramWEN=1, ramaddr=daddr[r], ramstore=dstore[r].
  - Each word completes on ACCESS with dwait[r]=0. The cache advances daddr between words.
- Coherence (cctrans[r]) enters SNOOP.
  - ccwait[o]=1 and ccsnoopaddr[o]=daddr[r] from SNOOP through the end of the transaction.
  - ccinv[o]=ccwrite[r] latched at grant.
  - SNOOP lasts exactly 1 cycle. At its end, sample ccwrite[o]:
    - ccwrite[o]=1: C2C0 then C2C1. ramWEN=1, ramaddr=daddr[o], ramstore=dstore[o], dload[r]=dstore[o]. On ACCESS, dwait[r]=0 and dwait[o]=0 in the same cycle. Memory is updated while forwarding.
    - else if dREN[r]: LOAD0 then LOAD1. ramREN=1, ramaddr=daddr[r], dload[r]=ramload, dwait[r]=0 on ACCESS.
    - else (S→M upgrade): INVONLY, 1 cycle, dwait[r]=0, then IDLE.
- After the second word, or after INVONLY/IFETCH, return to IDLE. ccwait/ccinv drop on entering IDLE.
- ramstate BUSY, FREE or ERROR during an access state: hold state and outputs. ERROR is never treated as completion.

## Timing
- Reset values:
  - iwait=dwait=2'b11; ccwait=ccinv=0; ccsnoopaddr=0.
  - ramREN=ramWEN=0; ramaddr=ramstore=0; iload=dload=0.
  - State IDLE; dptr=iptr=0.
- RST asserted mid-transaction: RAM strobes and ccwait drop combinationally. The block is in IDLE on the next edge after release; no partial completion is signalled.
- All outputs are Moore, from registered state and r, plus ramload/ramstate/dstore pass-through.
- IDLE to first RAM strobe: 1 cycle (grant edge). Coherence adds 1 cycle for SNOOP.
- Minimum latency with zero-wait RAM (ACCESS on first access cycle):
  - ifetch 2 cycles; write-back 3; load 4; cache-to-cache 4; upgrade 3.
- Requests deasserted mid-transaction are ignored. The transaction completes on state alone.
- Same-address coherence requests from both CPUs: serialized. The loser is snooped, and invalidated if the winner's ccwrite=1, before being granted.

## Test plan
- Single ifetch: iREN[0]=1, iaddr[0]=0x40, RAM returns 0xDEADBEEF after 2 BUSY cycles → iload[0]=0xDEADBEEF, iwait[0] low for 1 cycle, 4 cycles total.
- Data priority and fairness: iREN=2'b11 and dREN=2'b11 held, all with cctrans=1 → order CPU1 data, CPU0 data, then ifetches. Repeating the pattern alternates data grants.
- Cache-to-cache: CPU0 cctrans+dREN+ccwrite at 0x100; CPU1 asserts ccwrite in SNOOP with dstore 0xA, then 0xB → dload[0]=0xA/0xB, ramWEN at 0x100/0x104, ccinv[1]=1, both dwait pulse low together.
- Upgrade: CPU1 cctrans+ccwrite, no dREN → ccinv[0]=1 for SNOOP+INVONLY, no RAM strobe, dwait[1] low after 2 cycles.
- Write-back with ERROR: ramstate=ERROR for 3 cycles, then ACCESS → state held, dwait stays high until ACCESS.
- Reset mid-LOAD1: RST pulsed → ramREN=0 immediately, dwait=2'b11, next grant starts from IDLE with dptr=0.

Source files
------------

// File: rtl/coherence_bus_ctrl_if.sv
// Cache-side and RAM-side signal bundle for the two-CPU coherence bus controller.
// The controller connects through the master modport; caches and RAM use slave.
interface coherence_bus_ctrl_if;
    logic [1:0]       iREN;
    logic [1:0][31:0] iaddr;
    logic [1:0]       dREN;
    logic [1:0]       dWEN;
    logic [1:0][31:0] daddr;
    logic [1:0][31:0] dstore;
    logic [1:0]       ccwrite;
    logic [1:0]       cctrans;
    logic [31:0]      ramload;
    logic [1:0]       ramstate;

    logic [1:0]       iwait;
    logic [1:0]       dwait;
    logic [1:0][31:0] iload;
    logic [1:0][31:0] dload;
    logic [1:0]       ccwait;
    logic [1:0]       ccinv;
    logic [1:0][31:0] ccsnoopaddr;
    logic [31:0]      ramaddr;
    logic [31:0]      ramstore;
    logic             ramREN;
    logic             ramWEN;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ccwrite, cctrans, ramload, ramstate,
        output iwait, dwait, iload, dload, ccwait, ccinv, ccsnoopaddr,
               ramaddr, ramstore, ramREN, ramWEN
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ccwrite, cctrans, ramload, ramstate,
        input  iwait, dwait, iload, dload, ccwait, ccinv, ccsnoopaddr,
               ramaddr, ramstore, ramREN, ramWEN
    );
endinterface

// File: rtl/coherence_bus_ctrl.sv
// Two-CPU snooping coherence controller: arbitrates ifetch, block load, write-back
// and coherence transactions onto one RAM port, with cache-to-cache dirty forwarding.
module coherence_bus_ctrl (
    input  logic                  clk,
    input  logic                  rst,
    coherence_bus_ctrl_if.master  bus
);

    typedef enum logic [3:0] {
        IDLE, IFETCH, WB0, WB1, SNOOP, C2C0, C2C1, LOAD0, LOAD1, INVONLY
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    state_t     state_q, state_d;
    logic       r_q, r_d;
    logic       dptr_q, dptr_d;
    logic       iptr_q, iptr_d;
    logic       inv_q, inv_d;
    logic       coh_q, coh_d;

    logic [1:0] dreq;
    logic       access;
    logic       o;
    logic       win;

    assign dreq   = bus.dREN | bus.dWEN | bus.cctrans;
    assign access = (bus.ramstate == RAM_ACCESS);
    assign o      = ~r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= 1'b0;
            dptr_q  <= 1'b0;
            iptr_q  <= 1'b0;
            inv_q   <= 1'b0;
            coh_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            dptr_q  <= dptr_d;
            iptr_q  <= iptr_d;
            inv_q   <= inv_d;
            coh_q   <= coh_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        dptr_d  = dptr_q;
        iptr_d  = iptr_q;
        inv_d   = inv_q;
        coh_d   = coh_q;
        win     = 1'b0;
        case (state_q)
            IDLE: begin
                // Data beats instructions; on a tie the CPU not named by the pointer wins.
                if (|dreq) begin
                    win   = (&dreq) ? ~dptr_q : dreq[1];
                    r_d   = win;
                    coh_d = bus.cctrans[win];
                    inv_d = bus.ccwrite[win];
                    if (bus.cctrans[win])   state_d = SNOOP;
                    else if (bus.dWEN[win]) state_d = WB0;
                    else                    state_d = LOAD0;
                end else if (|bus.iREN) begin
                    win     = (&bus.iREN) ? ~iptr_q : bus.iREN[1];
                    r_d     = win;
                    coh_d   = 1'b0;
                    inv_d   = 1'b0;
                    state_d = IFETCH;
                end
            end
            IFETCH: if (access) begin
                state_d = IDLE;
                iptr_d  = ~iptr_q;
            end
            WB0:   if (access) state_d = WB1;
            WB1:   if (access) begin
                state_d = IDLE;
                dptr_d  = ~dptr_q;
            end
            SNOOP: begin
                if (bus.ccwrite[o])     state_d = C2C0;
                else if (bus.dREN[r_q]) state_d = LOAD0;
                else                    state_d = INVONLY;
            end
            C2C0:  if (access) state_d = C2C1;
            C2C1:  if (access) begin
                state_d = IDLE;
                dptr_d  = ~dptr_q;
            end
            LOAD0: if (access) state_d = LOAD1;
            LOAD1: if (access) begin
                state_d = IDLE;
                dptr_d  = ~dptr_q;
            end
            INVONLY: begin
                state_d = IDLE;
                dptr_d  = ~dptr_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.iwait       = '1;
        bus.dwait       = '1;
        bus.iload       = '0;
        bus.dload       = '0;
        bus.ccwait      = '0;
        bus.ccinv       = '0;
        bus.ccsnoopaddr = '0;
        bus.ramaddr     = '0;
        bus.ramstore    = '0;
        bus.ramREN      = 1'b0;
        bus.ramWEN      = 1'b0;
        // The snooped cache stays stalled for the whole coherence transaction.
        if (coh_q && state_q != IDLE) begin
            bus.ccwait[o]      = 1'b1;
            bus.ccinv[o]       = inv_q;
            bus.ccsnoopaddr[o] = bus.daddr[r_q];
        end
        case (state_q)
            IFETCH: begin
                bus.ramREN     = 1'b1;
                bus.ramaddr    = bus.iaddr[r_q];
                bus.iload[r_q] = bus.ramload;
                bus.iwait[r_q] = ~access;
            end
            WB0, WB1: begin
                bus.ramWEN     = 1'b1;
                bus.ramaddr    = bus.daddr[r_q];
                bus.ramstore   = bus.dstore[r_q];
                bus.dwait[r_q] = ~access;
            end
            C2C0, C2C1: begin
                bus.ramWEN     = 1'b1;
                bus.ramaddr    = bus.daddr[o];
                bus.ramstore   = bus.dstore[o];
                bus.dload[r_q] = bus.dstore[o];
                bus.dwait[r_q] = ~access;
                bus.dwait[o]   = ~access;
            end
            LOAD0, LOAD1: begin
                bus.ramREN     = 1'b1;
                bus.ramaddr    = bus.daddr[r_q];
                bus.dload[r_q] = bus.ramload;
                bus.dwait[r_q] = ~access;
            end
            INVONLY: bus.dwait[r_q] = 1'b0;
            default: ;
        endcase
    end

endmodule
